key_fifo_mmio: RTL and testbench
================================

# key_fifo_mmio

Memory-mapped keyboard input queue between the processor's data-memory port and the dmem instance. It buffers scancodes arriving from the PS/2 receiver in a FIFO and presents queue status and head code to the processor at a reserved dmem address. It passes all other dmem traffic through unchanged. It optionally discards PS/2 break sequences (F0 xx), so game code sees only make codes.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2–16.
- KEY_ADDR, 12'd4000: status/pop address. KEY_ADDR+1 is the flush address.
- FILTER_BREAK, 1: when 1, drop byte F0 and the byte that follows it.

Ports:
- clock  in  1  master clock, shared with the processor; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  in  8  scancode byte from the PS/2 receiver.
- proc_address  in  12  processor address_dmem.
- proc_wren  in  1  processor dmem write enable.
- proc_data  in  32  processor write data.
- proc_q  out  32  read data returned to the processor.
- mem_address  out  12  to dmem; always equals proc_address.
- mem_wren  out  1  to dmem.
- mem_data  out  32  to dmem; always equals proc_data.
- mem_q  in  32  dmem read data.
- irq_pending  out  1  registered; 1 while the FIFO is non-empty.

## Operation
- **Status word.** Combinational: {nonempty, overflow, 14'b0, count[7:0] zero-extended, head[7:0]}.
  - Bit 31 is nonempty; bit 30 is overflow.
  - head is 8'h00 when the FIFO is empty.
- **Read mux.** proc_q = status word when proc_address == KEY_ADDR, else 32'h0 when proc_address == KEY_ADDR+1, else mem_q. Select is combinational on proc_address.
- **Write decode.** mem_wren = proc_wren & ~(proc_address == KEY_ADDR | proc_address == KEY_ADDR+1). Reserved addresses never reach dmem.
- **Pop.** proc_wren at KEY_ADDR (data ignored) advances the read pointer if count > 0. Ignored if the FIFO is empty.
- **Flush.** proc_wren at KEY_ADDR+1 zeroes both pointers, count and overflow, and returns the filter FSM to IDLE.
- **Push.** A key_valid byte that passes the filter is written at the write pointer.
  - If count == DEPTH and no pop occurs in the same cycle, the byte is dropped and overflow is set (sticky).
- **Filter FSM** (FILTER_BREAK=1), states IDLE and SKIP:
  - IDLE, key_code==F0: drop the byte, go to SKIP.
  - IDLE, other byte: push it, stay in IDLE.
  - SKIP, any byte: drop it, go to IDLE.
  - With FILTER_BREAK=0 the FSM stays in IDLE and every byte is pushed.
  - E0 prefixes are pushed as ordinary bytes.
- **Pointers.** log2(DEPTH) bits wide and wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- **Simultaneous events:**
  - Push and pop with count>0: both occur, count unchanged. This includes count==DEPTH, where the push is accepted and overflow is not set.
  - Push and pop with count==0: only the push occurs, count becomes 1.
  - Flush with a push in the same cycle: flush wins, the byte is dropped, and overflow stays 0.
- **Reset.** Pointers=0, count=0, overflow=0, FSM=IDLE, irq_pending=0. FIFO storage contents are don't-care.
  - Reset mid-operation discards all queued bytes and any pending SKIP.
  - Pass-through outputs follow their inputs combinationally during reset; mem_wren is still masked at the reserved addresses.

## Timing
- Push to visibility: 1 cycle. A byte strobed in cycle N appears in the status word (count, head) from cycle N+1.
- Pop/flush to visibility: 1 cycle. The status in the write cycle still shows the pre-pop head.
- irq_pending: registered from the next-state count, so it reflects the same cycle boundary as count.
- Read mux and write mask add zero cycles. dmem's ~clock read timing is unchanged for non-reserved addresses.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- **Reset then simple push.** Reset high 2 cycles: status=32'h0, irq_pending=0. Push 1C: next cycle status=32'h8000_011C, irq_pending=1.
- **FIFO ordering and pops.** Push 1C, 1B, 23. Pop three times: head reads 1C, 1B, 23 in turn, then status=0. A fourth pop leaves count=0.
- **Overflow and flush.** DEPTH=8; push 9 bytes without popping: count=8, bit30=1, head = first byte. Write to KEY_ADDR+1: status=0 next cycle.
- **Break filter.** Feed 1C, F0, 1C, 75 with FILTER_BREAK=1: only 1C and 75 are queued (count=2). With FILTER_BREAK=0: count=4.
- **Simultaneous events.** At full: push+pop in the same cycle gives count=8, overflow=0. At empty: push+pop gives count=1. Flush+push gives count=0.
- **Pass-through.** Write and read at address 12'd100: mem_wren=1 and proc_q=mem_q. Write at KEY_ADDR: mem_wren=0. Mid-queue reset (count=3): next cycle status=0 and the FSM is in IDLE (F0 then 1C then 2A queues only 2A).

Source files
------------

// File: rtl/key_fifo_mmio.sv
// Keyboard scancode FIFO mapped into the processor's data-memory space.
// Buffers PS/2 bytes, optionally drops break sequences, and passes other dmem traffic through.
module key_fifo_mmio #(
    parameter int          DEPTH        = 8,
    parameter logic [11:0] KEY_ADDR     = 12'd4000,
    parameter bit          FILTER_BREAK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [11:0] proc_address,
    input  logic        proc_wren,
    input  logic [31:0] proc_data,
    output logic [31:0] proc_q,
    output logic [11:0] mem_address,
    output logic        mem_wren,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_q,
    output logic        irq_pending
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [11:0]      FLUSH_ADDR = KEY_ADDR + 12'd1;
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SKIP} filt_state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             overflow;
    filt_state_t      state;
    filt_state_t      state_nxt;
    logic             pass_byte;

    logic        hit_key;
    logic        hit_flush;
    logic        flush_do;
    logic        pop_do;
    logic        push_req;
    logic        push_do;
    logic        ovf_set;
    logic [7:0]  head;
    logic [31:0] status;

    assign hit_key   = (proc_address == KEY_ADDR);
    assign hit_flush = (proc_address == FLUSH_ADDR);
    assign flush_do  = proc_wren & hit_flush;
    assign pop_do    = proc_wren & hit_key & (count != '0);
    assign push_req  = key_valid & pass_byte & ~flush_do;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push_do   = push_req & ((count != FULL) | pop_do);
    assign ovf_set   = push_req & (count == FULL) & ~pop_do;

    assign mem_address = proc_address;
    assign mem_data    = proc_data;
    assign mem_wren    = proc_wren & ~(hit_key | hit_flush);

    assign head   = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign status = {(count != '0), overflow, 14'b0, 8'(count), head};

    always_comb begin
        if (hit_key)
            proc_q = status;
        else if (hit_flush)
            proc_q = 32'h0;
        else
            proc_q = mem_q;
    end

    // Break filter: F0 and the byte after it never reach the queue.
    always_comb begin
        state_nxt = state;
        pass_byte = 1'b1;
        if (FILTER_BREAK && key_valid) begin
            case (state)
                IDLE: begin
                    if (key_code == 8'hF0) begin
                        pass_byte = 1'b0;
                        state_nxt = SKIP;
                    end
                end
                SKIP: begin
                    pass_byte = 1'b0;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (flush_do)
            state_nxt = IDLE;
    end

    always_comb begin
        count_nxt = count;
        if (flush_do)
            count_nxt = '0;
        else if (push_do && !pop_do)
            count_nxt = count + CNT_W'(1);
        else if (pop_do && !push_do)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            state       <= IDLE;
            irq_pending <= 1'b0;
        end else begin
            if (flush_do) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (pop_do)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push_do)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (ovf_set)
                    overflow <= 1'b1;
            end
            count       <= count_nxt;
            state       <= state_nxt;
            irq_pending <= (count_nxt != '0);
        end
    end

    // Storage carries no reset; entries are only visible once counted.
    always_ff @(posedge clock) begin
        if (push_do)
            mem[wr_ptr] <= key_code;
    end

endmodule

// File: tb/tb_key_fifo_mmio.sv
// Randomized and directed bench for key_fifo_mmio against a queue-based model.
// Two instances share stimulus: one with break filtering, one without.
module tb_key_fifo_mmio;

    localparam int          DEPTH      = 8;
    localparam logic [11:0] KEY_ADDR   = 12'd4000;
    localparam logic [11:0] FLUSH_ADDR = 12'd4001;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [11:0] proc_address;
    logic        proc_wren;
    logic [31:0] proc_data;
    logic [31:0] mem_q;
    logic [31:0] q_fb, q_nf;
    logic [11:0] ma_fb, ma_nf;
    logic        mw_fb, mw_nf;
    logic [31:0] md_fb, md_nf;
    logic        irq_fb, irq_nf;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq1[$];
    logic [7:0] mq0[$];
    bit ovf1, ovf0, skip1;

    always #5 clock = ~clock;

    key_fifo_mmio #(.DEPTH(DEPTH), .KEY_ADDR(KEY_ADDR), .FILTER_BREAK(1'b1)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .proc_address(proc_address), .proc_wren(proc_wren), .proc_data(proc_data),
        .proc_q(q_fb), .mem_address(ma_fb), .mem_wren(mw_fb), .mem_data(md_fb),
        .mem_q(mem_q), .irq_pending(irq_fb)
    );

    key_fifo_mmio #(.DEPTH(DEPTH), .KEY_ADDR(KEY_ADDR), .FILTER_BREAK(1'b0)) dut_nf (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .proc_address(proc_address), .proc_wren(proc_wren), .proc_data(proc_data),
        .proc_q(q_nf), .mem_address(ma_nf), .mem_wren(mw_nf), .mem_data(md_nf),
        .mem_q(mem_q), .irq_pending(irq_nf)
    );

    function automatic logic [31:0] exp_fb();
        logic [7:0] h;
        h = (mq1.size() > 0) ? mq1[0] : 8'h00;
        return {(mq1.size() > 0), ovf1, 14'b0, 8'(mq1.size()), h};
    endfunction

    function automatic logic [31:0] exp_nf();
        logic [7:0] h;
        h = (mq0.size() > 0) ? mq0[0] : 8'h00;
        return {(mq0.size() > 0), ovf0, 14'b0, 8'(mq0.size()), h};
    endfunction

    // One clock: model consumes the inputs present at the edge, then inputs go idle
    // with the status address selected so proc_q shows the status word.
    task automatic tick();
        bit flush_w, pop_w, pop1, pop0, acc1;
        int sz1, sz0;
        @(posedge clock);
        if (reset) begin
            mq1.delete(); mq0.delete();
            ovf1 = 0; ovf0 = 0; skip1 = 0;
        end else begin
            flush_w = proc_wren && (proc_address == FLUSH_ADDR);
            pop_w   = proc_wren && (proc_address == KEY_ADDR);
            if (flush_w) begin
                mq1.delete(); mq0.delete();
                ovf1 = 0; ovf0 = 0; skip1 = 0;
            end else begin
                acc1 = 0;
                if (key_valid) begin
                    if (skip1) skip1 = 0;
                    else if (key_code == 8'hF0) skip1 = 1;
                    else acc1 = 1;
                end
                sz1 = mq1.size();
                sz0 = mq0.size();
                pop1 = pop_w && sz1 > 0;
                pop0 = pop_w && sz0 > 0;
                if (pop1) void'(mq1.pop_front());
                if (pop0) void'(mq0.pop_front());
                if (acc1) begin
                    if (sz1 < DEPTH || pop1) mq1.push_back(key_code);
                    else ovf1 = 1;
                end
                if (key_valid) begin
                    if (sz0 < DEPTH || pop0) mq0.push_back(key_code);
                    else ovf0 = 1;
                end
            end
        end
        #1;
        key_valid    = 1'b0;
        key_code     = 8'h00;
        proc_wren    = 1'b0;
        proc_address = KEY_ADDR;
        proc_data    = $urandom;
        mem_q        = $urandom;
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        key_valid = 1'b1;
        key_code  = b;
        tick();
    endtask

    task automatic pop_once();
        proc_wren    = 1'b1;
        proc_address = KEY_ADDR;
        tick();
    endtask

    task automatic flush_once();
        proc_wren    = 1'b1;
        proc_address = FLUSH_ADDR;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        proc_address = KEY_ADDR;
        proc_wren = 1'b1;
        #1;
        checks++;
        if (mw_fb !== 1'b0 || ma_fb !== KEY_ADDR) begin
            $display("FAIL reset_mask mem_wren=%0b addr=%0d required 0/%0d", mw_fb, ma_fb, KEY_ADDR);
            errors++;
        end
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (q_fb !== 32'h0 || q_nf !== 32'h0) begin
            $display("FAIL reset_status got %h/%h required 00000000", q_fb, q_nf);
            errors++;
        end
        checks++;
        if (irq_fb !== 1'b0 || irq_nf !== 1'b0) begin
            $display("FAIL reset_irq got %0b/%0b required 0", irq_fb, irq_nf);
            errors++;
        end
    endtask

    task automatic test_simple_push();
        push_byte(8'h1C);
        checks++;
        if (q_fb !== 32'h8000_011C || q_fb !== exp_fb()) begin
            $display("FAIL simple_push got %h required 8000011c", q_fb);
            errors++;
        end
        checks++;
        if (irq_fb !== 1'b1) begin
            $display("FAIL simple_irq got %0b required 1", irq_fb);
            errors++;
        end
    endtask

    task automatic test_ordering();
        logic [7:0] seq [3] = '{8'h1C, 8'h1B, 8'h23};
        flush_once();
        foreach (seq[i]) push_byte(seq[i]);
        foreach (seq[i]) begin
            checks++;
            if (q_fb[7:0] !== seq[i] || q_fb !== exp_fb()) begin
                $display("FAIL order_head%0d got %h required head %h model %h", i, q_fb, seq[i], exp_fb());
                errors++;
            end
            pop_once();
        end
        checks++;
        if (q_fb !== 32'h0 || irq_fb !== 1'b0) begin
            $display("FAIL order_empty got %h irq %0b required 0", q_fb, irq_fb);
            errors++;
        end
        pop_once();
        checks++;
        if (q_fb !== 32'h0) begin
            $display("FAIL pop_empty got %h required 00000000", q_fb);
            errors++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] first, b;
        flush_once();
        first = 8'h00;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hF0) b = 8'h11;
            if (i == 0) first = b;
            push_byte(b);
        end
        checks++;
        if (q_fb !== {1'b1, 1'b1, 14'b0, 8'd8, first} || q_fb !== exp_fb()) begin
            $display("FAIL overflow got %h required %h", q_fb, {1'b1, 1'b1, 14'b0, 8'd8, first});
            errors++;
        end
        proc_wren = 1'b1;
        proc_address = FLUSH_ADDR;
        mem_q = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (q_fb !== 32'h0 || mw_fb !== 1'b0) begin
            $display("FAIL flush_read got %h wren %0b required 0/0", q_fb, mw_fb);
            errors++;
        end
        tick();
        checks++;
        if (q_fb !== 32'h0 || irq_fb !== 1'b0) begin
            $display("FAIL flush got %h irq %0b required 0", q_fb, irq_fb);
            errors++;
        end
    endtask

    task automatic test_filter();
        logic [7:0] seq [4] = '{8'h1C, 8'hF0, 8'h1C, 8'h75};
        flush_once();
        foreach (seq[i]) push_byte(seq[i]);
        checks++;
        if (q_fb !== 32'h8000_021C || q_fb !== exp_fb()) begin
            $display("FAIL filter_on got %h required 8000021c", q_fb);
            errors++;
        end
        checks++;
        if (q_nf !== 32'h8000_041C || q_nf !== exp_nf()) begin
            $display("FAIL filter_off got %h required 8000041c", q_nf);
            errors++;
        end
        pop_once();
        checks++;
        if (q_fb[7:0] !== 8'h75) begin
            $display("FAIL filter_second got %h required head 75", q_fb[7:0]);
            errors++;
        end
    endtask

    task automatic test_simultaneous();
        flush_once();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h30 + i));
        key_valid = 1'b1; key_code = 8'h42;
        proc_wren = 1'b1; proc_address = KEY_ADDR;
        tick();
        checks++;
        if (q_fb !== {1'b1, 1'b0, 14'b0, 8'd8, 8'h31} || q_fb !== exp_fb()) begin
            $display("FAIL full_push_pop got %h required 80000831", q_fb);
            errors++;
        end
        flush_once();
        key_valid = 1'b1; key_code = 8'h55;
        proc_wren = 1'b1; proc_address = KEY_ADDR;
        tick();
        checks++;
        if (q_fb !== 32'h8000_0155 || q_fb !== exp_fb()) begin
            $display("FAIL empty_push_pop got %h required 80000155", q_fb);
            errors++;
        end
        key_valid = 1'b1; key_code = 8'h66;
        proc_wren = 1'b1; proc_address = FLUSH_ADDR;
        tick();
        checks++;
        if (q_fb !== 32'h0 || q_nf !== 32'h0) begin
            $display("FAIL flush_push got %h/%h required 00000000", q_fb, q_nf);
            errors++;
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] d, m;
        d = $urandom; m = $urandom;
        proc_address = 12'd100; proc_wren = 1'b1; proc_data = d; mem_q = m;
        #1;
        checks++;
        if (mw_fb !== 1'b1 || ma_fb !== 12'd100 || md_fb !== d) begin
            $display("FAIL pass_write wren %0b addr %0d data %h required 1/100/%h", mw_fb, ma_fb, md_fb, d);
            errors++;
        end
        checks++;
        if (q_fb !== m) begin
            $display("FAIL pass_read got %h required %h", q_fb, m);
            errors++;
        end
        tick();
        proc_address = KEY_ADDR; proc_wren = 1'b1;
        #1;
        checks++;
        if (mw_fb !== 1'b0) begin
            $display("FAIL key_mask got %0b required 0", mw_fb);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        flush_once();
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        push_byte(8'hF0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (q_fb !== 32'h0 || irq_fb !== 1'b0) begin
            $display("FAIL mid_reset got %h irq %0b required 0", q_fb, irq_fb);
            errors++;
        end
        push_byte(8'hF0); push_byte(8'h1C); push_byte(8'h2A);
        checks++;
        if (q_fb !== 32'h8000_012A || q_fb !== exp_fb()) begin
            $display("FAIL post_reset_fsm got %h required 8000012a", q_fb);
            errors++;
        end
    endtask

    task automatic test_random();
        int r;
        flush_once();
        for (int n = 0; n < 400; n++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
            r = $urandom_range(0, 11);
            if (r < 4) begin
                proc_wren = 1'b1; proc_address = KEY_ADDR;
            end else if (r == 4) begin
                proc_wren = 1'b1; proc_address = FLUSH_ADDR;
            end else if (r == 5) begin
                proc_wren = 1'b1; proc_address = 12'($urandom_range(0, 3999));
            end
            tick();
            checks++;
            if (q_fb !== exp_fb()) begin
                $display("FAIL rand_fb[%0d] got %h required %h", n, q_fb, exp_fb());
                errors++;
            end
            checks++;
            if (q_nf !== exp_nf()) begin
                $display("FAIL rand_nf[%0d] got %h required %h", n, q_nf, exp_nf());
                errors++;
            end
            checks++;
            if (irq_fb !== (mq1.size() > 0) || irq_nf !== (mq0.size() > 0)) begin
                $display("FAIL rand_irq[%0d] got %0b/%0b required %0b/%0b", n, irq_fb, irq_nf,
                         mq1.size() > 0, mq0.size() > 0);
                errors++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        proc_address = KEY_ADDR; proc_wren = 1'b0; proc_data = 32'h0; mem_q = 32'h0;
        ovf1 = 0; ovf0 = 0; skip1 = 0;
        test_reset();
        test_simple_push();
        test_ordering();
        test_overflow();
        test_filter();
        test_simultaneous();
        test_passthrough();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
